// File: rtl/alu_mdu_pkg.sv
// Shared op codes and FSM state encoding for the EX-stage ALU with iterative MDU.
package alu_mdu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLTU  = 4'b0011;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
   localparam logic [OP_W-1:0] OP_MULT  = 4'b1000;
   localparam logic [OP_W-1:0] OP_MULTU = 4'b1001;
   localparam logic [OP_W-1:0] OP_DIV   = 4'b1010;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'b1011;
   localparam logic [OP_W-1:0] OP_NOR   = 4'b1100;
   localparam logic [OP_W-1:0] OP_XOR   = 4'b1101;
   localparam logic [OP_W-1:0] OP_MFHI  = 4'b1110;
   localparam logic [OP_W-1:0] OP_MFLO  = 4'b1111;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

endpackage

// File: rtl/mdu_core.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with sign fix-up
// applied combinationally to the final registers (read by the top in its FIN cycle).
module mdu_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,   // 0 = multiply, 1 = divide
   input  logic         sgn,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,   // final iteration completes at this edge
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         dz
);

   localparam int CNTW = $clog2(W) + 1;

   logic            r_busy, r_mode, r_neg_lo, r_neg_hi, r_dz;
   logic [CNTW-1:0] r_cnt;
   logic [W-1:0]    r_hi, r_lo, r_op, r_a;

   logic            w_a_neg, w_b_neg;
   logic [W-1:0]    w_a_mag, w_b_mag;
   logic [W:0]      w_sum;
   logic [W+1:0]    w_sh, w_tr;
   logic            w_qb;
   logic [2*W-1:0]  w_prod;

   assign w_a_neg = sgn & a[W-1];
   assign w_b_neg = sgn & b[W-1];
   assign w_a_mag = w_a_neg ? -a : a;
   assign w_b_mag = w_b_neg ? -b : b;

   // multiply: r_lo holds the multiplier and shifts out as product bits shift in
   assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
   // divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in
   assign w_sh  = {1'b0, r_hi, r_lo[W-1]};
   assign w_tr  = w_sh - {2'b00, r_op};
   assign w_qb  = ~w_tr[W+1];

   assign done  = r_busy && (r_cnt == CNTW'(W-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_mode   <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_dz     <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_op     <= '0;
         r_a      <= '0;
      end else if (start) begin
         r_busy   <= 1'b1;
         r_mode   <= mode;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= mode ? w_a_mag : w_b_mag;
         r_op     <= mode ? w_b_mag : w_a_mag;
         r_neg_lo <= w_a_neg ^ w_b_neg;
         r_neg_hi <= w_a_neg;
         r_dz     <= mode && (b == '0);
         r_a      <= a;
      end else if (r_busy) begin
         r_cnt <= r_cnt + 1'b1;
         if (done) r_busy <= 1'b0;
         if (!r_mode) begin
            {r_hi, r_lo} <= {w_sum, r_lo[W-1:1]};
         end else begin
            r_hi <= w_qb ? w_tr[W-1:0] : w_sh[W-1:0];
            r_lo <= {r_lo[W-2:0], w_qb};
         end
      end
   end

   assign w_prod = {r_hi, r_lo};

   always_comb begin
      hi = '0;
      lo = '0;
      dz = 1'b0;
      if (!r_mode) begin
         {hi, lo} = r_neg_lo ? -w_prod : w_prod;
      end else if (r_dz) begin
         hi = r_a;
         lo = '1;
         dz = 1'b1;
      end else begin
         lo = r_neg_lo ? -r_lo : r_lo;
         hi = r_neg_hi ? -r_hi : r_hi;
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with HI/LO and an iterative multiply/divide unit behind a
// valid/ready handshake; single-cycle ops stream one per cycle while IDLE.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int W  = 32,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] ctl,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          out_valid,
   output logic [W-1:0]  out,
   output logic          z,
   output logic          ovf,
   output logic          dz
);

   state_t          r_state, w_next;
   logic [W-1:0]    r_hi, r_lo, r_out;
   logic            r_z, r_ovf, r_dz, r_out_valid;

   logic [OP_W-1:0] w_op;
   logic            w_acc, w_is_mul, w_is_div, w_start, w_sgn;
   logic [W-1:0]    w_sum, w_dif, w_res;
   logic            w_ovf;
   logic            w_done, w_core_dz;
   logic [W-1:0]    w_core_hi, w_core_lo;

   assign w_op     = OP_W'(ctl);
   assign in_ready = (r_state == IDLE);
   assign w_acc    = in_valid && in_ready;
   assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
   assign w_is_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);
   assign w_start  = w_acc && (w_is_mul || w_is_div);
   assign w_sgn    = (w_op == OP_MULT) || (w_op == OP_DIV);

   mdu_core #(.W(W)) u_mdu (
      .clk   (clk),
      .rst   (rst),
      .start (w_start),
      .mode  (w_is_div),
      .sgn   (w_sgn),
      .a     (a),
      .b     (b),
      .done  (w_done),
      .hi    (w_core_hi),
      .lo    (w_core_lo),
      .dz    (w_core_dz)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_start) w_next = w_is_mul ? MUL : DIV;
         MUL,
         DIV:  if (w_done) w_next = FIN;
         FIN:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_sum = a + b;
   assign w_dif = a - b;

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (w_op)
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_NOR:  w_res = ~(a | b);
         OP_XOR:  w_res = a ^ b;
         OP_ADD: begin
            w_res = w_sum;
            w_ovf = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
         end
         OP_SUB: begin
            w_res = w_dif;
            w_ovf = (a[W-1] != b[W-1]) && (w_dif[W-1] != a[W-1]);
         end
         OP_SLT:  w_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: w_res = {{(W-1){1'b0}}, a < b};
         OP_MFHI: w_res = r_hi;
         OP_MFLO: w_res = r_lo;
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi        <= '0;
         r_lo        <= '0;
         r_out       <= '0;
         r_z         <= 1'b0;
         r_ovf       <= 1'b0;
         r_dz        <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_acc && !w_start) begin
            r_out       <= w_res;
            r_z         <= (w_res == '0);
            r_ovf       <= w_ovf;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b1;
         end
         // HI/LO are architectural: only the FIN cycle commits them
         if (r_state == FIN) begin
            r_hi        <= w_core_hi;
            r_lo        <= w_core_lo;
            r_out       <= w_core_lo;
            r_z         <= (w_core_lo == '0);
            r_ovf       <= 1'b0;
            r_dz        <= w_core_dz;
            r_out_valid <= 1'b1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out       = r_out;
   assign z         = r_z;
   assign ovf       = r_ovf;
   assign dz        = r_dz;

endmodule
